// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, op           request and opcode (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   src_a, src_b        operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo              HI/LO registers
//   busy, done          registered status: op in flight / one-cycle result pulse
//   stall               combinational hold request to the core
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0]   mag_a, mag_a_n, mag_b, mag_b_n;
    logic               sign_a, sign_a_n, sign_b, sign_b_n;
    logic               is_div, is_div_n;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic               busy_n, done_n;

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_tmp;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    assign mul_tmp  = {mul_sum, acc[WIDTH-1:0]};
    assign mul_next = mul_tmp[2*WIDTH:1];

    // Restoring divide step: acc holds {remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // Sign fix-up values used in FIX.
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo, rem, raw_a;
    assign neg_res  = sign_a ^ sign_b;
    assign prod_neg = -acc;
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    assign raw_a    = sign_a ? -mag_a : mag_a;

    assign stall = busy | (start & ~op[2]);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            mag_a  <= mag_a_n;
            mag_b  <= mag_b_n;
            sign_a <= sign_a_n;
            sign_b <= sign_b_n;
            is_div <= is_div_n;
            hi     <= hi_n;
            lo     <= lo_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        mag_a_n  = mag_a;
        mag_b_n  = mag_b;
        sign_a_n = sign_a;
        sign_b_n = sign_b;
        is_div_n = is_div;
        hi_n     = hi;
        lo_n     = lo;
        done_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            // op[0] set marks the unsigned variants.
                            sign_a_n = ~op[0] & src_a[WIDTH-1];
                            sign_b_n = ~op[0] & src_b[WIDTH-1];
                            mag_a_n  = sign_a_n ? -src_a : src_a;
                            mag_b_n  = sign_b_n ? -src_b : src_b;
                            is_div_n = op[1];
                            cnt_n    = '0;
                            acc_n    = op[1] ? {{WIDTH{1'b0}}, mag_a_n} : {{WIDTH{1'b0}}, mag_b_n};
                            state_n  = op[1] ? S_DIV : S_MUL;
                        end
                        OP_MTHI: hi_n = src_a;
                        OP_MTLO: lo_n = src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_n = mul_next;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) state_n = S_FIX;
            end
            S_DIV: begin
                acc_n = div_next;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) state_n = S_FIX;
            end
            S_FIX: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                if (!is_div) begin
                    {hi_n, lo_n} = neg_res ? prod_neg : acc;
                end else if (mag_b == '0) begin
                    hi_n = raw_a;
                    lo_n = {WIDTH{1'b1}};
                end else begin
                    lo_n = neg_res ? -quo : quo;
                    hi_n = sign_a ? -rem : rem;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t         exp_q[$];
    res_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           t0 = 0;
    logic [W-1:0] hold_hi, hold_lo;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .stall (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", hi, mon_e.hi);
                check("result_lo", lo, mon_e.lo);
            end
        end
    end

    // Waits for done; checks latency, stall/busy while running and HI/LO holding.
    task automatic wait_done();
        int bad  = 0;
        int lat  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - t0;
                break;
            end
            if (!stall || !busy || hi !== hold_hi || lo !== hold_lo) bad++;
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 100 cycles expected done at cycle 34");
            return;
        end
        check("latency", 32'(lat), 32'd34);
        check("run_cycles_bad", 32'(bad), 32'd0);
        check("busy_in_done", 32'(busy), 32'd0);
        check("stall_in_done", 32'(stall), 32'd0);
    endtask

    // Issue one multiply/divide op at the current negedge; optionally try an MTHI mid-op.
    task automatic mdop(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int mt_at);
        hold_hi = hi;
        hold_lo = lo;
        op = o; src_a = a; src_b = b; start = 1'b1;
        t0 = cyc;
        exp_q.push_back({eh, el});
        #1;
        check("stall_cycle0", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0; src_a = ~a; src_b = ~b;
        if (mt_at > 0) begin
            repeat (mt_at) @(negedge clk);
            op = OP_MTHI; src_a = 32'hDEAD_BEEF; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    // Single-cycle MTHI/MTLO.
    task automatic mtop(input logic [2:0] o, input logic [W-1:0] a);
        op = o; src_a = a; start = 1'b1;
        #1;
        check("mt_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("mt_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // MTHI / MTLO visible the cycle after; the other register untouched.
        mtop(OP_MTHI, 32'hA5A5_A5A5);
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo", lo, 32'h0);
        mtop(OP_MTLO, 32'h5A5A_5A5A);
        check("mtlo_lo", lo, 32'h5A5A_5A5A);
        check("mtlo_hi", hi, 32'hA5A5_A5A5);

        // NOP opcode changes nothing.
        op = 3'b111; src_a = 32'h1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nop_hi", hi, 32'hA5A5_A5A5);
        check("nop_lo", lo, 32'h5A5A_5A5A);
        check("nop_busy", 32'(busy), 32'd0);

        // Reset in cycle 10 of a MULT clears HI/LO and busy immediately.
        op = OP_MULT; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        mdop(OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 0);
        mdop(OP_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        mdop(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
        mdop(OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15, 0);
        mdop(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        mdop(OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 0);
        mdop(OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
        mdop(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
        mdop(OP_DIVU,  32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 0);
        mdop(OP_DIV,   32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);

        // MTHI during a DIVU is ignored; HI ends up with the remainder.
        mdop(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 5);

        // Back-to-back: second op issued in the first op's done cycle.
        mdop(OP_MULTU, 32'd5, 32'd6, 32'h0, 32'd30, 0);
        mdop(OP_MULTU, 32'd7, 32'd8, 32'h0, 32'd56, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
